// File: rtl/reg_bank_ctrl.sv
// Bank controller for a windowed register file: current bank, return stack and writeback bank pipe.
// Optional perf counters are enabled by defining REG_BANK_PERF_EN.
module reg_bank_ctrl #(
    parameter int NUM_BANKS   = 5,
    parameter int BANK_W      = 3,
    parameter int STACK_DEPTH = 8,
    parameter int WB_LAT      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic                             pipe_stall,
    input  logic                             call_req,
    input  logic                             ret_req,
    input  logic                             we_in,
    output logic [BANK_W-1:0]                sel_read,
    output logic [BANK_W-1:0]                sel_write,
    output logic                             we_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             ovf_err,
    output logic                             unf_err,
    output logic [15:0]                      call_cnt,
    output logic [15:0]                      ret_cnt,
    output logic [$clog2(STACK_DEPTH+1)-1:0] max_depth
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] bank;
    } pipe_ent_t;

    logic [BANK_W-1:0]  sel_read_q, sel_read_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [BANK_W-1:0]  wr_hold_q;
    pipe_ent_t          pipe_q [WB_LAT];
    pipe_ent_t          pipe_d [WB_LAT];
    logic [BANK_W-1:0]  stack_q [STACK_DEPTH];
    logic               push, pop;
    logic [BANK_W-1:0]  next_bank;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    pipe_ent_t          tail;

    assign next_bank = (sel_read_q == BANK_W'(NUM_BANKS - 1)) ? '0 : sel_read_q + 1'b1;
    assign wr_ptr    = depth_q[PTR_W-1:0];
    assign rd_ptr    = PTR_W'(depth_q - 1'b1);
    assign tail      = pipe_q[WB_LAT-1];

    // Simultaneous call and return cancel out: no switch, no error, no count.
    always_comb begin
        sel_read_d = sel_read_q;
        depth_d    = depth_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (call_req && !ret_req) begin
            if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                push       = 1'b1;
                sel_read_d = next_bank;
                depth_d    = depth_q + 1'b1;
            end
        end else if (ret_req && !call_req) begin
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                pop        = 1'b1;
                sel_read_d = stack_q[rd_ptr];
                depth_d    = depth_q - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WB_LAT; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (!pipe_stall) begin
            pipe_d[0] = '{valid: issue_valid, bank: sel_read_q};
            for (int i = 1; i < WB_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_read_q <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wr_hold_q  <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            sel_read_q <= sel_read_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wr_hold_q  <= sel_write;
            for (int i = 0; i < WB_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // NOTE: stack storage is left unreset; depth_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_ptr] <= sel_read_q;
        end
    end

    assign sel_read  = sel_read_q;
    assign sel_write = tail.valid ? tail.bank : wr_hold_q;
    assign we_out    = we_in & tail.valid;
    assign depth     = depth_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

`ifdef REG_BANK_PERF_EN
    logic [15:0]        call_cnt_q, ret_cnt_q;
    logic [DEPTH_W-1:0] max_depth_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            call_cnt_q  <= '0;
            ret_cnt_q   <= '0;
            max_depth_q <= '0;
        end else begin
            if (push && call_cnt_q != 16'hFFFF) call_cnt_q <= call_cnt_q + 1'b1;
            if (pop && ret_cnt_q != 16'hFFFF)   ret_cnt_q  <= ret_cnt_q + 1'b1;
            if (depth_d > max_depth_q)          max_depth_q <= depth_d;
        end
    end

    assign call_cnt  = call_cnt_q;
    assign ret_cnt   = ret_cnt_q;
    assign max_depth = max_depth_q;
`else
    assign call_cnt  = '0;
    assign ret_cnt   = '0;
    assign max_depth = '0;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed testbench for reg_bank_ctrl with hand-computed expectations.
// Counter checks follow REG_BANK_PERF_EN the same way the design does.
module tb_reg_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst, issue_valid, pipe_stall, call_req, ret_req, we_in;
    logic [2:0] sel_read, sel_write;
    logic       we_out, ovf_err, unf_err;
    logic [3:0] depth, max_depth;
    logic [15:0] call_cnt, ret_cnt;

    int n_cmp = 0;
    int n_err = 0;

    reg_bank_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .pipe_stall  (pipe_stall),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .we_in       (we_in),
        .sel_read    (sel_read),
        .sel_write   (sel_write),
        .we_out      (we_out),
        .depth       (depth),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err),
        .call_cnt    (call_cnt),
        .ret_cnt     (ret_cnt),
        .max_depth   (max_depth)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_core(input string tag, input int sr, input int dp);
        check({tag, ".sel_read"}, 16'(sel_read), 16'(sr));
        check({tag, ".depth"},    16'(depth),    16'(dp));
    endtask

    int exp_call5 [5] = '{1, 2, 3, 4, 0};
    int exp_ret5  [5] = '{4, 3, 2, 1, 0};
    int exp_call8 [8] = '{1, 2, 3, 4, 0, 1, 2, 3};
    int exp_ret8  [8] = '{2, 1, 0, 4, 3, 2, 1, 0};

    initial begin
        rst = 1'b1; issue_valid = 1'b0; pipe_stall = 1'b0;
        call_req = 1'b0; ret_req = 1'b0; we_in = 1'b0;

        // 1. reset then idle with we_in high
        tick(); tick();
        rst = 1'b0; we_in = 1'b1;
        tick();
        check_core("reset", 0, 0);
        check("reset.sel_write", 16'(sel_write), 16'd0);
        check("reset.we_out",    16'(we_out),    16'd0);
        check("reset.ovf",       16'(ovf_err),   16'd0);
        check("reset.unf",       16'(unf_err),   16'd0);
        check("reset.call_cnt",  call_cnt,       16'd0);

        // 2. call while issuing: old bank for the request-cycle instruction
        issue_valid = 1'b1; call_req = 1'b1;
        tick();
        call_req = 1'b0;
        check_core("lat.c4", 1, 1);
        check("lat.c4.we_out", 16'(we_out), 16'd0);
        tick();
        check("lat.c5.sel_write", 16'(sel_write), 16'd0);
        check("lat.c5.we_out",    16'(we_out),    16'd1);
        tick();
        check("lat.c6.sel_write", 16'(sel_write), 16'd1);
        issue_valid = 1'b0; ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check_core("lat.ret", 0, 0);
        tick();
        check("lat.hold.sel_write", 16'(sel_write), 16'd1);
        check("lat.hold.we_out",    16'(we_out),    16'd0);
        tick();

        // 3. five calls wrap the bank ID, five returns unwind it
        call_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_core($sformatf("call5[%0d]", i), exp_call5[i], i + 1);
        end
        call_req = 1'b0; ret_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_core($sformatf("ret5[%0d]", i), exp_ret5[i], 4 - i);
        end
        ret_req = 1'b0;

        // 4. overflow and underflow pulses
        call_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_core($sformatf("call8[%0d]", i), exp_call8[i], i + 1);
        end
        check("full.ovf_pre", 16'(ovf_err), 16'd0);
        tick();
        call_req = 1'b0;
        check("ovf.pulse", 16'(ovf_err), 16'd1);
        check_core("ovf", 3, 8);
        tick();
        check("ovf.clear", 16'(ovf_err), 16'd0);
        ret_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_core($sformatf("ret8[%0d]", i), exp_ret8[i], 7 - i);
        end
        check("empty.unf_pre", 16'(unf_err), 16'd0);
        tick();
        ret_req = 1'b0;
        check("unf.pulse", 16'(unf_err), 16'd1);
        check_core("unf", 0, 0);
        tick();
        check("unf.clear", 16'(unf_err), 16'd0);

        // 5. simultaneous call/return, then a stalled pipe
        call_req = 1'b1;
        tick(); tick();
        ret_req = 1'b1;
        tick();
        call_req = 1'b0; ret_req = 1'b0;
        check_core("both", 2, 2);
        check("both.ovf", 16'(ovf_err), 16'd0);
        check("both.unf", 16'(unf_err), 16'd0);
        issue_valid = 1'b1;
        tick(); tick();
        issue_valid = 1'b0;
        tick();
        check("prestall.sel_write", 16'(sel_write), 16'd2);
        check("prestall.we_out",    16'(we_out),    16'd1);
        pipe_stall = 1'b1; call_req = 1'b1;
        tick();
        call_req = 1'b0;
        check_core("stall.call", 3, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall[%0d].sel_write", i), 16'(sel_write), 16'd2);
            check($sformatf("stall[%0d].we_out", i),    16'(we_out),    16'd1);
            if (i < 2) tick();
        end
        we_in = 1'b0;
        #1;
        check("stall.we_gate", 16'(we_out), 16'd0);
        we_in = 1'b1;

        // 6. reset mid-operation with a valid pipe
        pipe_stall = 1'b0; issue_valid = 1'b1;
        tick();
        check("unstall.sel_write", 16'(sel_write), 16'd2);
        check("unstall.we_out",    16'(we_out),    16'd0);
        tick();
        check("prerst.sel_write", 16'(sel_write), 16'd3);
        check("prerst.we_out",    16'(we_out),    16'd1);
`ifdef REG_BANK_PERF_EN
        check("perf.call_cnt",  call_cnt,          16'd17);
        check("perf.ret_cnt",   ret_cnt,           16'd14);
        check("perf.max_depth", 16'(max_depth),    16'd8);
`else
        check("perf.call_cnt",  call_cnt,          16'd0);
        check("perf.ret_cnt",   ret_cnt,           16'd0);
        check("perf.max_depth", 16'(max_depth),    16'd0);
`endif
        rst = 1'b1;
        tick();
        check_core("midrst", 0, 0);
        check("midrst.we_out",    16'(we_out),    16'd0);
        check("midrst.sel_write", 16'(sel_write), 16'd0);
        check("midrst.call_cnt",  call_cnt,       16'd0);
        check("midrst.ret_cnt",   ret_cnt,        16'd0);
        check("midrst.max_depth", 16'(max_depth), 16'd0);
        rst = 1'b0; issue_valid = 1'b0;
        tick();
        check("postrst.we_out", 16'(we_out), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
